// File: rtl/mem_port_arbiter_pkg.sv
// Shared core types: data width, RAM write width and the read-owner tag used
// by the memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    write_byte = 2'd0,
    write_half = 2'd1,
    write_word = 2'd2
  } write_width_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } mem_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port data RAM arbiter between fetch (read-only) and memory stage.
// Optional fetch anti-starvation counter is compiled in with MEM_ARB_FAIR_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_STALL = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  write_width_t      d_wwidth,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic [XLEN-1:0]   ram_addr,
  output logic [XLEN-1:0]   ram_w_data,
  output write_width_t      ram_w_width,
  output logic              ram_w_enable,
  input  logic [XLEN-1:0]   ram_r_data
);

  if (MAX_STALL < 1) begin : g_bad_param
    $error("MAX_STALL must be at least 1");
  end

  mem_owner_t owner_q, owner_d;
  logic       fair_force;

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  logic [SW-1:0] stall_cnt_q, stall_cnt_d;

  assign fair_force = (stall_cnt_q == STALL_MAX);

  // Counts consecutive cycles fetch waited; any idle or granted cycle restarts it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!if_req || if_gnt) stall_cnt_d = '0;
    else if (stall_cnt_q != STALL_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end
`else
  assign fair_force = 1'b0;
`endif

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (if_req && (!d_req || fair_force)) if_gnt = 1'b1;
      else if (d_req)                       d_gnt  = 1'b1;
    end
  end

  assign ram_addr     = d_gnt ? d_addr : if_addr;
  assign ram_w_data   = d_wdata;
  assign ram_w_width  = d_wwidth;
  assign ram_w_enable = d_gnt & d_we;

  // Writes return nothing, so they leave no owner behind.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt)              owner_d = OWN_IF;
    else if (d_gnt && !d_we) owner_d = OWN_D;
  end

  always_ff @(posedge clock) begin
    if (reset) owner_q <= OWN_NONE;
    else       owner_q <= owner_d;
  end

  // Gated by reset so a read granted just before reset never reports data.
  assign if_rvalid = (owner_q == OWN_IF) & ~reset;
  assign d_rvalid  = (owner_q == OWN_D)  & ~reset;
  assign if_rdata  = ram_r_data;
  assign d_rdata   = ram_r_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-enabled RAM model and a
// transaction-level reference that predicts grants and returned read data.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAXS = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [XLEN-1:0]   if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [XLEN-1:0]   if_rdata;
  logic              d_req = 1'b0, d_we = 1'b0;
  logic [XLEN-1:0]   d_addr = '0, d_wdata = '0;
  write_width_t      d_wwidth = write_word;
  logic              d_gnt, d_rvalid;
  logic [XLEN-1:0]   d_rdata;
  logic [XLEN-1:0]   ram_addr, ram_w_data;
  write_width_t      ram_w_width;
  logic              ram_w_enable;
  logic [XLEN-1:0]   ram_r_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.MAX_STALL(MAXS)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wwidth(d_wwidth), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_w_width(ram_w_width),
    .ram_w_enable(ram_w_enable), .ram_r_data(ram_r_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)  return 32'hDEADBEEF;
    if (i == 12) return 32'h11223344;
    return 32'hA5A50000 | i;
  endfunction

  // RAM model: registered read, byte-lane enables on write.
  logic [31:0] ram [64];
  initial for (int i = 0; i < 64; i++) ram[i] = init_word(i);

  always @(posedge clock) begin
    logic [3:0]  be;
    logic [31:0] sh;
    int          idx;
    idx = int'(ram_addr[7:2]);
    case (ram_w_width)
      write_byte: begin be = 4'b0001 << ram_addr[1:0]; sh = ram_w_data << (8 * ram_addr[1:0]); end
      write_half: begin be = 4'b0011 << {ram_addr[1], 1'b0}; sh = ram_w_data << (16 * ram_addr[1]); end
      default:    begin be = 4'b1111; sh = ram_w_data; end
    endcase
    if (ram_w_enable)
      for (int b = 0; b < 4; b++) if (be[b]) ram[idx][b*8 +: 8] <= sh[b*8 +: 8];
    ram_r_data <= ram[idx];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-request transaction view, not cycle structure.
  logic [31:0] ref_mem [64];
  initial for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

  bit          started = 0;
  bit          pend_if = 0, pend_d = 0;
  logic [31:0] exp_data = '0;
  int          waited = 0;

  always @(negedge clock) begin
    bit          e_if, e_d, fair_en, fetch_wins;
    logic [31:0] w;
    int          idx;
`ifdef MEM_ARB_FAIR_EN
    fair_en = 1;
`else
    fair_en = 0;
`endif
    if (reset) started = 1;
    if (started) begin
      fetch_wins = if_req && (!d_req || (fair_en && waited >= MAXS));
      e_if = !reset && fetch_wins;
      e_d  = !reset && d_req && !fetch_wins;
      chk("if_gnt", {31'd0, if_gnt}, {31'd0, e_if});
      chk("d_gnt", {31'd0, d_gnt}, {31'd0, e_d});
      chk("ram_w_enable", {31'd0, ram_w_enable}, {31'd0, e_d && d_we});
      if (e_d) chk("ram_addr_d", ram_addr, d_addr);
      else     chk("ram_addr_if", ram_addr, if_addr);
      chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, pend_if && !reset});
      chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, pend_d && !reset});
      if (pend_if && !reset) chk("if_rdata", if_rdata, exp_data);
      if (pend_d && !reset)  chk("d_rdata", d_rdata, exp_data);
      if (reset) begin
        pend_if = 0; pend_d = 0; waited = 0;
      end else begin
        pend_if = e_if;
        pend_d  = e_d && !d_we;
        idx = int'((e_d ? d_addr : if_addr) >> 2) % 64;
        if (e_if || (e_d && !d_we)) exp_data = ref_mem[idx];
        if (e_d && d_we) begin
          w = ref_mem[idx];
          case (d_wwidth)
            write_byte: w[8*d_addr[1:0] +: 8] = d_wdata[7:0];
            write_half: if (d_addr[1]) w[31:16] = d_wdata[15:0]; else w[15:0] = d_wdata[15:0];
            default:    w = d_wdata;
          endcase
          ref_mem[idx] = w;
        end
        if (if_req && !e_if) waited = (waited < MAXS) ? waited + 1 : MAXS;
        else                 waited = 0;
      end
    end
  end

  task automatic drv(input logic rst, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic we, input logic [31:0] da,
                     input logic [31:0] wd, input write_width_t ww);
    reset = rst; if_req = ir; if_addr = ia;
    d_req = dr; d_we = we; d_addr = da; d_wdata = wd; d_wwidth = ww;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, write_word);
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  initial begin
    // Reset with both requesting a write: nothing may be granted.
    drv(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h0, write_word);
    @(negedge clock);
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("rst_w_enable", {31'd0, ram_w_enable}, 32'd0);
    tick();
    idle(); tick();

    // Fetch-only read of word 4.
    drv(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, write_word);
    @(negedge clock); chk("fetch_gnt", {31'd0, if_gnt}, 32'd1);
    tick(); idle();
    @(negedge clock);
    chk("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
    chk("fetch_no_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    tick();

    // Conflict: data wins by default.
    drv(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, write_word);
    @(negedge clock);
    chk("conf_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("conf_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("conf_ram_addr", ram_addr, 32'h20);
    tick(); idle();
    @(negedge clock);
    chk("conf_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("conf_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    tick();

    // Byte write into 0x11223344 then read back.
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h31, 32'hAB, write_byte);
    @(negedge clock); chk("wr_enable", {31'd0, ram_w_enable}, 32'd1);
    tick();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, write_word);
    @(negedge clock);
    chk("wr_enable_drop", {31'd0, ram_w_enable}, 32'd0);
    chk("wr_no_rvalid", {30'd0, d_rvalid, if_rvalid}, 32'd0);
    tick(); idle();
    @(negedge clock);
    chk("rb_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("rb_rdata", d_rdata, 32'h1122AB44);
    tick();

    // Back-to-back fetch then data read.
    drv(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, write_word);
    tick();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, write_word);
    @(negedge clock);
    chk("b2b_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("b2b_d_gnt", {31'd0, d_gnt}, 32'd1);
    tick(); idle();
    @(negedge clock);
    chk("b2b_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("b2b_d_rdata", d_rdata, 32'hA5A50001);
    tick();

    // Half write to upper lane, read back by fetch; word write, read by data under conflict.
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h42, 32'h1234BEEF, write_half);
    tick();
    drv(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h50, 32'hCAFEF00D, write_word);
    tick();
    drv(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, write_word);
    tick();
    drv(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h50, 32'h0, write_word);
    @(negedge clock);
    chk("half_rdata", if_rdata, 32'hBEEF0010);
    tick(); idle();
    @(negedge clock);
    chk("word_rdata", d_rdata, 32'hCAFEF00D);
    tick();

    // Reset right after a fetch grant drops the in-flight read.
    drv(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, write_word);
    tick();
    drv(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h4, 32'h0, write_word);
    @(negedge clock);
    chk("rstmid_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rstmid_gnts", {30'd0, if_gnt, d_gnt}, 32'd0);
    tick(); idle();
    @(negedge clock);
    chk("rstmid_after", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    tick();

    // Continuous conflict: fairness pattern.
    for (int i = 0; i < 12; i++) begin
      drv(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, write_word);
      @(negedge clock);
`ifdef MEM_ARB_FAIR_EN
      chk("fair_if_gnt", {31'd0, if_gnt}, {31'd0, (i % 5) == 4});
`else
      chk("fair_if_gnt", {31'd0, if_gnt}, 32'd0);
`endif
      tick();
    end
    idle(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, byte-enabled data RAM between two requesters:
  - the instruction-fetch stage (read-only)
  - the memory stage (read/write)
- The RAM has 1-cycle registered read latency, so the block grants one access per cycle and tracks which requester owns the in-flight read.
- It steers returning read data back to that requester with a valid strobe.
- Sits between the pipeline stages and the RAM instance.

Parameters:
- XLEN, 32, data/address width; comes from the shared package and is not overridden per instance.
- MAX_STALL, 4, consecutive lost arbitrations before fetch is forced to win; only used when the fairness feature is compiled in.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch requests a word read this cycle.
- if_addr  input  XLEN  fetch byte address.
- if_gnt  output  1  fetch request accepted this cycle (combinational).
- if_rvalid  output  1  if_rdata valid (cycle after grant).
- if_rdata  output  XLEN  fetch read data.
- d_req  input  1  memory stage requests an access.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  XLEN  data byte address.
- d_wdata  input  XLEN  write data, right-aligned.
- d_wwidth  input  write_width_t  byte/halfword/word.
- d_gnt  output  1  data request accepted this cycle (combinational).
- d_rvalid  output  1  d_rdata valid (cycle after read grant).
- d_rdata  output  XLEN  data read result.
- ram_addr  output  XLEN  to RAM addr.
- ram_w_data  output  XLEN  to RAM w_data.
- ram_w_width  output  write_width_t  to RAM w_width.
- ram_w_enable  output  1  to RAM w_enable.
- ram_r_data  input  XLEN  from RAM r_data.

Behaviour:
- Reset values:
  - Outputs: if_rvalid=0, d_rvalid=0.
  - State: owner=OWN_NONE, stall_cnt=0.
  - While reset=1: if_gnt=0, d_gnt=0, ram_w_enable=0.
- Grant, combinational, at most one per cycle:
  - d_req alone → d_gnt.
  - if_req alone → if_gnt.
  - Both requesting → d_gnt (fixed data priority) unless the fairness override applies.
- RAM steering:
  - ram_addr = d_addr when d_gnt, else if_addr (including idle).
  - ram_w_data = d_wdata.
  - ram_w_width = d_wwidth.
  - ram_w_enable = d_gnt & d_we.
- owner register, enum states OWN_NONE / OWN_IF / OWN_D, next value:
  - if_gnt → OWN_IF.
  - d_gnt & ~d_we → OWN_D.
  - Otherwise (write or no grant) → OWN_NONE.
- Read return, one cycle after grant:
  - if_rvalid = (owner==OWN_IF).
  - d_rvalid = (owner==OWN_D).
  - if_rdata = d_rdata = ram_r_data, pass-through; meaningful only while the matching rvalid is high.
- Back-to-back grants are allowed every cycle. A new grant may coincide with the rvalid of the previous read; both occur in the same cycle.
- A write followed next cycle by a read of the same word returns the written data; this follows from RAM write-before-read ordering across edges.
- A requester that is not granted must hold req/addr stable; the block does not latch requests.
- Reset asserted mid-read: owner is cleared, so no rvalid is produced the following cycle. In-flight data is dropped.
- Misaligned/boundary-crossing accesses are passed through unchecked.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- With MEM_ARB_FAIR_EN defined:
  - stall_cnt (width $clog2(MAX_STALL+1)) increments each cycle if_req=1 and if_gnt=0, saturating at MAX_STALL.
  - stall_cnt clears on if_gnt, on reset, or on any cycle with if_req=0.
  - When stall_cnt==MAX_STALL and both request, fetch wins that cycle.
- Without it: stall_cnt is absent and priority is strictly data-first.

Decomposition:
- Shared core package:
  - XLEN and write_width_t, existing.
  - Add mem_owner_t (OWN_NONE, OWN_IF, OWN_D).
- No sub-module; the fairness counter is small and stays inline under the macro guard.

Test Plan:
- Fetch-only read:
  - Stimulus: if_req=1, if_addr=0x10, RAM word 4 = 0xDEADBEEF.
  - Response: if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- Conflict, default priority:
  - Stimulus: both req, d_we=0, d_addr=0x20.
  - Response: d_gnt=1, if_gnt=0, ram_addr=0x20; next cycle d_rvalid=1 only.
- Write then read-back:
  - Stimulus: d_we=1, d_wwidth=write_byte, d_addr=0x31, d_wdata=0xAB over word 0x11223344; next cycle read 0x30.
  - Response: ram_w_enable=1 during the write cycle only, no rvalid for the write; read returns 0x1122AB44.
- Back-to-back alternation:
  - Stimulus: cycle0 fetch read 0x0, cycle1 data read 0x4.
  - Response: cycle1 if_rvalid=1, cycle2 d_rvalid=1, no gap.
- Reset mid-read:
  - Stimulus: fetch grant at cycle N, reset=1 at cycle N+1.
  - Response: if_rvalid=0 at N+1, all grants 0 during reset.
- Fairness (MEM_ARB_FAIR_EN, MAX_STALL=4):
  - Stimulus: both req continuously.
  - Response: d_gnt for 4 cycles, if_gnt on the 5th, then stall_cnt=0 and the pattern repeats.
  - Without the macro: if_gnt never asserts.
